vec_uop_seq: RTL and testbench
==============================

VEC_UOP_SEQ -- requirements
Module: vec_uop_seq

Interface
REQ-001 SHALL have parameter XLEN, default 32, scalar/instruction width.
REQ-002 SHALL have parameter VLEN, default 512, vector register width in bits.
REQ-003 SHALL have parameter VLMAX, default 512, maximum vl (SEW=8, LMUL=8); VLW = $clog2(VLMAX)+1.
REQ-004 SHALL have ports, one clock, asynchronous active-low reset:
 clk  in  1  clock, rising edge
 n_rst  in  1  asynchronous active-low reset
 inst_valid_i  in  1  vector instruction offered
 inst_ready_o  out  1  sequencer accepts instruction
 vec_inst_i  in  XLEN  instruction word
 vl_i  in  VLW  current vl from CSR decoder
 sew_i  in  3  vsew encoding
 lmul_i  in  3  vlmul encoding
 uop_valid_o  out  1  micro-op offered to lane datapath
 uop_ready_i  in  1  lane accepts micro-op
 uop_inst_o  out  XLEN  captured instruction word
 uop_vreg_off_o  out  3  register offset within LMUL group
 uop_elem_cnt_o  out  7  active elements in this micro-op (1..64)
 uop_first_o / uop_last_o  out  1 each  first/last micro-op of instruction
 uop_done_i  in  1  lane completion pulse, one per micro-op
 inst_done_o  out  1  one-cycle retire pulse
 busy_o  out  1  state != IDLE
 illegal_o  out  1  one-cycle pulse, unsupported SEW

Function
REQ-005 SHALL implement FSM IDLE, ISSUE, DRAIN; inst_ready_o = 1 only in IDLE.
REQ-006 On handshake (inst_valid_i & inst_ready_o), SHALL capture vec_inst_i, vl_i, sew_i, lmul_i; later input changes ignored until next acceptance.
REQ-007 Config instruction (opcode 7'h57, funct3 3'b111: vsetvli/vsetivli/vsetvl) SHALL pulse inst_done_o the next cycle, issue no micro-op, stay IDLE.
REQ-008 Elements per register epr = VLEN/SEW: SEW 000->64, 001->32, 010->16; sew 011..111 SHALL pulse illegal_o next cycle, issue nothing, stay IDLE, no inst_done_o.
REQ-009 Group size G: lmul 000/001/010/011 -> 1/2/4/8; fractional (101/110/111) and reserved 100 -> 1.
REQ-010 Effective vl = min(vl, epr*G); uop count N = ceil(vl_eff/epr).
REQ-011 vl_eff = 0 SHALL give inst_done_o next cycle, no micro-op, stay IDLE.
REQ-012 Otherwise -> ISSUE; first uop_valid_o asserted cycle after acceptance.
REQ-013 uop_valid_o and all uop_* outputs SHALL hold stable until uop_ready_i; one micro-op per cycle with uop_ready_i held high.
REQ-014 Micro-op k (0..N-1): uop_vreg_off_o = k; uop_elem_cnt_o = epr, except k = N-1 gets vl_eff - (N-1)*epr; uop_first_o at k=0, uop_last_o at k=N-1 (both if N=1).
REQ-015 After last micro-op handshake -> DRAIN; uop_valid_o deasserts that next cycle.
REQ-016 SHALL keep 4-bit outstanding counter: +1 per micro-op handshake, -1 per uop_done_i, net 0 when both same cycle.
REQ-017 uop_done_i with counter 0 SHALL be ignored (no underflow).
REQ-018 In DRAIN, cycle after counter reaches 0 -> IDLE with inst_done_o pulse that cycle; uop_done_i may also arrive during ISSUE.

Reset
REQ-019 n_rst low SHALL immediately force IDLE, counter 0, captured registers 0, uop_valid_o/inst_done_o/illegal_o/busy_o 0, inst_ready_o 1 (not while n_rst low: 0), all uop_* data 0.
REQ-020 Reset mid-ISSUE/DRAIN SHALL abandon instruction silently, no inst_done_o; first acceptance one cycle after n_rst rises.

Structure
REQ-021 Package vec_pkg SHALL hold XLEN/VLEN/VLMAX defaults, sew_e and lmul_e enums, state enum, OPC_VEC = 7'h57, F3_CFG = 3'b111.
REQ-022 Combinational sub-module vec_elem_calc SHALL compute epr, G, vl_eff, N, last count from sew/lmul/vl; FSM and counters in vec_uop_seq.

Verification
REQ-023 vl=16, sew=010, lmul=000, uop_ready_i=1 -> one micro-op, off 0, cnt 16, first=last=1; uop_done_i 2 cycles later -> inst_done_o next cycle.
REQ-024 vl=40, sew=010, lmul=010 -> three micro-ops off 0/1/2, cnt 16/16/8, back-to-back; uop_ready_i low 3 cycles on 2nd -> outputs stable, then resume.
REQ-025 vec_inst_i=32'h01007057 -> inst_done_o cycle after acceptance, no uop_valid_o; vl=0 normal instruction -> same.
REQ-026 sew=011 -> illegal_o single pulse, no micro-op; vl=600, sew=000, lmul=011 -> clamp 512, eight micro-ops cnt 64.
REQ-027 n_rst low after 2nd of 4 micro-ops -> uop_valid_o 0 immediately, no inst_done_o; next instruction sequences normally.
REQ-028 uop_done_i coinciding with micro-op handshake -> counter unchanged; spurious uop_done_i in IDLE -> no effect.

Source files
------------

// File: rtl/vec_pkg.sv
// Shared types and defaults for the vector micro-op sequencer.
// Holds the vsew/vlmul encodings, FSM states and the opcode fields that identify config instructions.
package vec_pkg;

  localparam int DEF_XLEN  = 32;
  localparam int DEF_VLEN  = 512;
  localparam int DEF_VLMAX = 512;

  localparam logic [6:0] OPC_VEC = 7'h57;
  localparam logic [2:0] F3_CFG  = 3'b111;

  typedef enum logic [2:0] {
    SEW_8  = 3'b000,
    SEW_16 = 3'b001,
    SEW_32 = 3'b010,
    SEW_64 = 3'b011
  } sew_e;

  typedef enum logic [2:0] {
    LMUL_1   = 3'b000,
    LMUL_2   = 3'b001,
    LMUL_4   = 3'b010,
    LMUL_8   = 3'b011,
    LMUL_RSV = 3'b100,
    LMUL_F8  = 3'b101,
    LMUL_F4  = 3'b110,
    LMUL_F2  = 3'b111
  } lmul_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/vec_uop_seq_if.sv
// Instruction-in / micro-op-out bundle of the sequencer; slave is the sequencer,
// master is the issue stage plus lane datapath that surround it.
interface vec_uop_seq_if
  import vec_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter int VLW  = $clog2(DEF_VLMAX) + 1
);
  logic            inst_valid_i;
  logic            inst_ready_o;
  logic [XLEN-1:0] vec_inst_i;
  logic [VLW-1:0]  vl_i;
  logic [2:0]      sew_i;
  logic [2:0]      lmul_i;
  logic            uop_valid_o;
  logic            uop_ready_i;
  logic [XLEN-1:0] uop_inst_o;
  logic [2:0]      uop_vreg_off_o;
  logic [6:0]      uop_elem_cnt_o;
  logic            uop_first_o;
  logic            uop_last_o;
  logic            uop_done_i;
  logic            inst_done_o;
  logic            busy_o;
  logic            illegal_o;

  modport slave (
    input  inst_valid_i, vec_inst_i, vl_i, sew_i, lmul_i, uop_ready_i, uop_done_i,
    output inst_ready_o, uop_valid_o, uop_inst_o, uop_vreg_off_o, uop_elem_cnt_o,
           uop_first_o, uop_last_o, inst_done_o, busy_o, illegal_o
  );

  modport master (
    output inst_valid_i, vec_inst_i, vl_i, sew_i, lmul_i, uop_ready_i, uop_done_i,
    input  inst_ready_o, uop_valid_o, uop_inst_o, uop_vreg_off_o, uop_elem_cnt_o,
           uop_first_o, uop_last_o, inst_done_o, busy_o, illegal_o
  );

endinterface

// File: rtl/vec_elem_calc.sv
// Combinational split of vl into per-register micro-ops: elements per register, clamped vl,
// micro-op count and the tail count. epr and G are powers of two, so everything reduces to shifts.
module vec_elem_calc
  import vec_pkg::*;
#(
  parameter int VLEN = DEF_VLEN,
  parameter int VLW  = $clog2(DEF_VLMAX) + 1
) (
  input  logic [2:0]     sew,
  input  logic [2:0]     lmul,
  input  logic [VLW-1:0] vl,
  output logic           legal,
  output logic [6:0]     epr,
  output logic [VLW-1:0] vl_eff,
  output logic [3:0]     n_uop,
  output logic [6:0]     last_cnt
);

  localparam int SH8 = $clog2(VLEN) - 3;

  logic [3:0]   esh;
  logic [3:0]   gsh;
  logic [VLW:0] cap;
  logic [VLW:0] rnd;

  always_comb begin
    legal = 1'b1;
    esh   = 4'(SH8);
    case (sew)
      SEW_8:   esh = 4'(SH8);
      SEW_16:  esh = 4'(SH8 - 1);
      SEW_32:  esh = 4'(SH8 - 2);
      default: legal = 1'b0;
    endcase

    // fractional and reserved LMUL still occupy one whole register
    gsh = 4'd0;
    case (lmul)
      LMUL_2:  gsh = 4'd1;
      LMUL_4:  gsh = 4'd2;
      LMUL_8:  gsh = 4'd3;
      default: gsh = 4'd0;
    endcase

    epr      = 7'd1 << esh;
    cap      = (VLW+1)'(1) << (esh + gsh);
    vl_eff   = ({1'b0, vl} < cap) ? vl : cap[VLW-1:0];
    rnd      = {1'b0, vl_eff} + ((VLW+1)'(1) << esh) - (VLW+1)'(1);
    n_uop    = 4'(rnd >> esh);
    last_cnt = 7'(vl_eff - (VLW'(n_uop - 4'd1) << esh));
  end

endmodule

// File: rtl/vec_uop_seq.sv
// Cracks one vector instruction into LMUL-group micro-ops, then waits for all lane completions.
// First micro-op one cycle after acceptance; micro-op fields hold while uop_ready_i is low.
module vec_uop_seq
  import vec_pkg::*;
#(
  parameter int XLEN  = DEF_XLEN,
  parameter int VLEN  = DEF_VLEN,
  parameter int VLMAX = DEF_VLMAX
) (
  input logic          clk,
  input logic          n_rst,
  vec_uop_seq_if.slave bus
);

  localparam int VLW = $clog2(VLMAX) + 1;

  state_e          state_q, state_d;
  logic [XLEN-1:0] inst_q;
  logic [VLW-1:0]  vl_q;
  logic [2:0]      sew_q, lmul_q;
  logic [2:0]      k_q, k_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            done_q, done_d, ill_q, ill_d, init_q;

  logic            idle, accept, uop_hs, done_eff, is_cfg, is_last;
  logic [VLW-1:0]  c_vl, vl_eff;
  logic [2:0]      c_sew, c_lmul;
  logic            legal;
  logic [6:0]      epr, last_cnt;
  logic [3:0]      n_uop;

  // while idle the calculator looks at the offered instruction so the accept cycle can classify it
  assign idle   = (state_q == ST_IDLE);
  assign c_vl   = idle ? bus.vl_i   : vl_q;
  assign c_sew  = idle ? bus.sew_i  : sew_q;
  assign c_lmul = idle ? bus.lmul_i : lmul_q;

  vec_elem_calc #(.VLEN(VLEN), .VLW(VLW)) u_calc (
    .sew      (c_sew),
    .lmul     (c_lmul),
    .vl       (c_vl),
    .legal    (legal),
    .epr      (epr),
    .vl_eff   (vl_eff),
    .n_uop    (n_uop),
    .last_cnt (last_cnt)
  );

  assign bus.inst_ready_o = idle & init_q;
  assign accept   = bus.inst_valid_i & bus.inst_ready_o;
  assign is_cfg   = (bus.vec_inst_i[6:0] == OPC_VEC) && (bus.vec_inst_i[14:12] == F3_CFG);
  assign uop_hs   = bus.uop_valid_o & bus.uop_ready_i;
  assign done_eff = bus.uop_done_i & (cnt_q != 4'd0);
  assign cnt_d    = cnt_q + {3'b000, uop_hs} - {3'b000, done_eff};
  assign is_last  = ({1'b0, k_q} == (n_uop - 4'd1));

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    done_d  = 1'b0;
    ill_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_cfg)                 done_d = 1'b1;
          else if (!legal)            ill_d  = 1'b1;
          else if (vl_eff == '0)      done_d = 1'b1;
          else begin
            state_d = ST_ISSUE;
            k_d     = 3'd0;
          end
        end
      end
      ST_ISSUE: begin
        if (uop_hs) begin
          if (is_last) state_d = ST_DRAIN;
          else         k_d     = k_q + 3'd1;
        end
      end
      ST_DRAIN: begin
        if (cnt_d == 4'd0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
      inst_q  <= '0;
      vl_q    <= '0;
      sew_q   <= '0;
      lmul_q  <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      ill_q   <= 1'b0;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      ill_q   <= ill_d;
      init_q  <= 1'b1;
      if (accept) begin
        inst_q <= bus.vec_inst_i;
        vl_q   <= bus.vl_i;
        sew_q  <= bus.sew_i;
        lmul_q <= bus.lmul_i;
      end
    end
  end

  assign bus.uop_valid_o    = (state_q == ST_ISSUE);
  assign bus.uop_inst_o     = inst_q;
  assign bus.uop_vreg_off_o = bus.uop_valid_o ? k_q : 3'd0;
  assign bus.uop_elem_cnt_o = !bus.uop_valid_o ? 7'd0 : (is_last ? last_cnt : epr);
  assign bus.uop_first_o    = bus.uop_valid_o & (k_q == 3'd0);
  assign bus.uop_last_o     = bus.uop_valid_o & is_last;
  assign bus.inst_done_o    = done_q;
  assign bus.illegal_o      = ill_q;
  assign bus.busy_o         = ~idle;

endmodule

// File: tb/tb_vec_uop_seq.sv
// Directed bench for vec_uop_seq: a vector table of whole instructions plus scripted
// sequences for backpressure, counter corner cases and mid-instruction reset.
module tb_vec_uop_seq;
  import vec_pkg::*;

  logic clk;
  logic n_rst;
  int   n_pass = 0;
  int   n_total = 0;

  vec_uop_seq_if #(.XLEN(32), .VLW(10)) bus ();

  vec_uop_seq #(.XLEN(32), .VLEN(512), .VLMAX(512)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  typedef struct {
    string       name;
    logic [31:0] inst;
    logic [9:0]  vl;
    logic [2:0]  sew;
    logic [2:0]  lmul;
    int          kind;   // 0 micro-ops, 1 immediate done, 2 illegal
    int          n;
    int          full;
    int          lastc;
    int          dly;
  } vec_t;

  typedef struct {
    int rdy, dn, vld, off, cnt, fst, lst, idn, bsy;
  } step_t;

  localparam logic [31:0] I_ADD = 32'h0200_8057;
  localparam logic [31:0] I_CFG = 32'h0100_7057;

  vec_t  tab[9];
  step_t sq[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d required %0d", nm, act, exp);
  endtask

  task automatic run_vec(input vec_t v);
    int due[$];
    int k;
    int seen;
    int idone_cyc;
    @(negedge clk);
    bus.inst_valid_i = 1'b1;
    bus.vec_inst_i   = v.inst;
    bus.vl_i         = v.vl;
    bus.sew_i        = v.sew;
    bus.lmul_i       = v.lmul;
    bus.uop_ready_i  = 1'b1;
    bus.uop_done_i   = 1'b0;
    chk({v.name, "_ready"}, bus.inst_ready_o, 1);
    @(negedge clk);
    // post-acceptance changes must not leak into the running instruction
    bus.inst_valid_i = 1'b0;
    bus.vec_inst_i   = 32'hffff_ffff;
    bus.vl_i         = 10'h3ff;
    bus.sew_i        = 3'b000;
    bus.lmul_i       = 3'b011;
    if (v.kind != 0) begin
      chk({v.name, "_idone"}, bus.inst_done_o, (v.kind == 1));
      chk({v.name, "_illegal"}, bus.illegal_o, (v.kind == 2));
      chk({v.name, "_no_uop"}, bus.uop_valid_o, 0);
      chk({v.name, "_busy"}, bus.busy_o, 0);
      @(negedge clk);
      chk({v.name, "_pulse_end"}, bus.inst_done_o | bus.illegal_o, 0);
    end else begin
      k = 0;
      seen = 0;
      idone_cyc = 0;
      for (int c = 1; c <= 40 && seen == 0; c++) begin
        if (c > 1) @(negedge clk);
        bus.uop_done_i = 1'b0;
        if (due.size() > 0 && due[0] == c) begin
          bus.uop_done_i = 1'b1;
          void'(due.pop_front());
        end
        if (bus.inst_done_o) begin
          seen = 1;
          idone_cyc = c;
        end else if (bus.uop_valid_o) begin
          chk({v.name, "_off"}, bus.uop_vreg_off_o, k);
          chk({v.name, "_cnt"}, bus.uop_elem_cnt_o, (k == v.n - 1) ? v.lastc : v.full);
          chk({v.name, "_first"}, bus.uop_first_o, (k == 0));
          chk({v.name, "_last"}, bus.uop_last_o, (k == v.n - 1));
          chk({v.name, "_inst"}, bus.uop_inst_o, v.inst);
          due.push_back(c + v.dly);
          k++;
        end
      end
      bus.uop_done_i = 1'b0;
      chk({v.name, "_nuop"}, k, v.n);
      chk({v.name, "_idone_cycle"}, idone_cyc, v.n + 1 + v.dly);
    end
  endtask

  initial begin
    int idn;

    tab[0] = '{"single",   I_ADD, 10'd16,  3'b010, 3'b000, 0, 1, 16, 16, 2};
    tab[1] = '{"three",    I_ADD, 10'd40,  3'b010, 3'b010, 0, 3, 16,  8, 1};
    tab[2] = '{"cfg",      I_CFG, 10'd40,  3'b010, 3'b000, 1, 0,  0,  0, 1};
    tab[3] = '{"vl_zero",  I_ADD, 10'd0,   3'b010, 3'b000, 1, 0,  0,  0, 1};
    tab[4] = '{"sew64",    I_ADD, 10'd16,  3'b011, 3'b000, 2, 0,  0,  0, 1};
    tab[5] = '{"clamp",    I_ADD, 10'd600, 3'b000, 3'b011, 0, 8, 64, 64, 1};
    tab[6] = '{"frac",     I_ADD, 10'd100, 3'b001, 3'b111, 0, 1, 32, 32, 1};
    tab[7] = '{"tail1",    I_ADD, 10'd33,  3'b001, 3'b001, 0, 2, 32,  1, 1};
    tab[8] = '{"cfg_sew7", I_CFG, 10'd16,  3'b111, 3'b000, 1, 0,  0,  0, 1};

    // rdy dn vld off cnt fst lst idn bsy
    sq[0] = '{1, 0, 1, 0, 16, 1, 0, 0, 1};
    sq[1] = '{0, 0, 1, 1, 16, 0, 0, 0, 1};
    sq[2] = '{0, 0, 1, 1, 16, 0, 0, 0, 1};
    sq[3] = '{0, 0, 1, 1, 16, 0, 0, 0, 1};
    sq[4] = '{1, 1, 1, 1, 16, 0, 0, 0, 1};
    sq[5] = '{1, 0, 1, 2,  8, 0, 1, 0, 1};
    sq[6] = '{1, 1, 0, 0,  0, 0, 0, 0, 1};
    sq[7] = '{0, 1, 0, 0,  0, 0, 0, 0, 1};
    sq[8] = '{0, 0, 0, 0,  0, 0, 0, 1, 0};
    sq[9] = '{0, 0, 0, 0,  0, 0, 0, 0, 0};

    n_rst            = 1'b0;
    bus.inst_valid_i = 1'b0;
    bus.vec_inst_i   = 32'h0;
    bus.vl_i         = 10'd0;
    bus.sew_i        = 3'd0;
    bus.lmul_i       = 3'd0;
    bus.uop_ready_i  = 1'b0;
    bus.uop_done_i   = 1'b0;

    @(negedge clk);
    chk("rst_ready", bus.inst_ready_o, 0);
    chk("rst_valid", bus.uop_valid_o, 0);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_idone", bus.inst_done_o, 0);
    chk("rst_illegal", bus.illegal_o, 0);
    chk("rst_uinst", bus.uop_inst_o, 0);
    chk("rst_off", bus.uop_vreg_off_o, 0);
    chk("rst_cnt", bus.uop_elem_cnt_o, 0);
    chk("rst_first_last", {bus.uop_first_o, bus.uop_last_o}, 0);
    n_rst = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", bus.inst_ready_o, 1);

    for (int i = 0; i < 9; i++) run_vec(tab[i]);

    // stray completions while idle must not disturb the outstanding count
    @(negedge clk);
    bus.uop_done_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.uop_done_i = 1'b0;
    chk("spurious_busy", bus.busy_o, 0);
    chk("spurious_idone", bus.inst_done_o, 0);

    bus.inst_valid_i = 1'b1;
    bus.vec_inst_i   = I_ADD;
    bus.vl_i         = 10'd40;
    bus.sew_i        = 3'b010;
    bus.lmul_i       = 3'b010;
    @(negedge clk);
    bus.inst_valid_i = 1'b0;
    bus.vl_i         = 10'd5;
    bus.sew_i        = 3'b000;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      bus.uop_ready_i = sq[i].rdy[0];
      bus.uop_done_i  = sq[i].dn[0];
      chk($sformatf("bp%0d_valid", i), bus.uop_valid_o, sq[i].vld);
      chk($sformatf("bp%0d_off", i), bus.uop_vreg_off_o, sq[i].off);
      chk($sformatf("bp%0d_cnt", i), bus.uop_elem_cnt_o, sq[i].cnt);
      chk($sformatf("bp%0d_first", i), bus.uop_first_o, sq[i].fst);
      chk($sformatf("bp%0d_last", i), bus.uop_last_o, sq[i].lst);
      chk($sformatf("bp%0d_idone", i), bus.inst_done_o, sq[i].idn);
      chk($sformatf("bp%0d_busy", i), bus.busy_o, sq[i].bsy);
      if (sq[i].vld != 0) chk($sformatf("bp%0d_inst", i), bus.uop_inst_o, I_ADD);
    end
    bus.uop_done_i = 1'b0;

    // reset in the middle of a four micro-op instruction
    @(negedge clk);
    bus.inst_valid_i = 1'b1;
    bus.vec_inst_i   = I_ADD;
    bus.vl_i         = 10'd64;
    bus.sew_i        = 3'b010;
    bus.lmul_i       = 3'b010;
    bus.uop_ready_i  = 1'b1;
    @(negedge clk);
    bus.inst_valid_i = 1'b0;
    chk("mid_u0_off", bus.uop_vreg_off_o, 0);
    @(negedge clk);
    chk("mid_u1_off", bus.uop_vreg_off_o, 1);
    @(negedge clk);
    chk("mid_u2_valid", bus.uop_valid_o, 1);
    chk("mid_u2_off", bus.uop_vreg_off_o, 2);
    n_rst = 1'b0;
    #1;
    chk("mid_rst_valid", bus.uop_valid_o, 0);
    chk("mid_rst_busy", bus.busy_o, 0);
    chk("mid_rst_ready", bus.inst_ready_o, 0);
    chk("mid_rst_cnt", bus.uop_elem_cnt_o, 0);
    @(negedge clk);
    n_rst = 1'b1;
    idn = 0;
    @(negedge clk);
    chk("mid_rel_ready", bus.inst_ready_o, 1);
    idn += int'(bus.inst_done_o);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      idn += int'(bus.inst_done_o);
    end
    chk("mid_no_idone", idn, 0);
    run_vec(tab[1]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
